// File: rtl/reflet_int_arbiter_if.sv
// Bus and interrupt-handshake signals of the reflet interrupt arbiter.
// master drives bus/CPU/exti side; slave is the arbiter itself.
interface reflet_int_arbiter_if #(
  parameter int unsigned addr_width = 16
);
  logic                  enable;
  logic [addr_width-1:0] addr;
  logic                  write_en;
  logic [7:0]            data_in;
  logic [7:0]            data_out;
  logic [3:0]            ext_int;
  logic                  int_req;
  logic [1:0]            int_num;
  logic                  int_ack;
  logic                  int_ret;

  modport master (
    output enable, addr, write_en, data_in, ext_int, int_ack, int_ret,
    input  data_out, int_req, int_num
  );

  modport slave (
    input  enable, addr, write_en, data_in, ext_int, int_ack, int_ret,
    output data_out, int_req, int_num
  );
endinterface

// File: rtl/reflet_int_arbiter.sv
// Four-line nested interrupt arbiter: edge-detected pending bits, priority
// over the currently active level, and a two-state request/ack handshake.
module reflet_int_arbiter #(
  parameter int unsigned                base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF07
) (
  input logic                 clk,
  input logic                 reset,
  reflet_int_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                    state, state_next;
  logic                      ctrl_en, ctrl_next;
  logic [3:0]                pending, pending_next;
  logic [3:0]                active, active_next;
  logic [3:0]                prev;
  logic                      primed;
  logic [1:0]                int_num, num_next;

  logic [base_addr_size-1:0] offset;
  logic                      sel, wr;
  logic [1:0]                reg_idx;
  logic [3:0]                rise, w1c, ack_mask, ret_mask;
  logic                      ack, cur_valid, cand_valid;
  logic [1:0]                cur_level, cand;

  assign offset  = bus.addr - base_addr;
  assign sel     = bus.enable && (offset < base_addr_size'(3));
  assign wr      = sel && bus.write_en;
  assign reg_idx = offset[1:0];

  assign bus.int_req = (state == REQ);
  assign bus.int_num = int_num;

  always_comb begin
    bus.data_out = '0;
    if (sel) begin
      case (reg_idx)
        2'd0:    bus.data_out = {7'h00, ctrl_en};
        2'd1:    bus.data_out = {4'h0, pending};
        2'd2:    bus.data_out = {4'h0, active};
        default: bus.data_out = '0;
      endcase
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_level = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (active[i]) begin
        cur_valid = 1'b1;
        cur_level = 2'(i);
      end
    end
    // A candidate must outrank every active line, so active lines never qualify.
    cand_valid = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pending[i] && (!cur_valid || (2'(i) > cur_level))) begin
        cand_valid = 1'b1;
        cand       = 2'(i);
      end
    end
  end

  always_comb begin
    // No edges are seen on the first sample after reset, so lines held high
    // through reset do not raise pending.
    rise     = primed ? (bus.ext_int & ~prev) : '0;
    w1c      = (wr && (reg_idx == 2'd1)) ? bus.data_in[3:0] : '0;
    ack      = (state == REQ) && bus.int_ack;
    ack_mask = ack ? (4'b0001 << int_num) : '0;
    ret_mask = (bus.int_ret && cur_valid) ? (4'b0001 << cur_level) : '0;

    pending_next = (pending & ~w1c & ~ack_mask) | rise;
    active_next  = (active & ~ret_mask) | ack_mask;
    ctrl_next    = (wr && (reg_idx == 2'd0)) ? bus.data_in[0] : ctrl_en;

    state_next = state;
    num_next   = int_num;
    case (state)
      IDLE: begin
        if (ctrl_en && cand_valid) begin
          state_next = REQ;
          num_next   = cand;
        end
      end
      REQ: begin
        if (ack || !pending_next[int_num] || !ctrl_next) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl_en <= 1'b0;
      pending <= '0;
      active  <= '0;
      prev    <= '0;
      primed  <= 1'b0;
      int_num <= '0;
    end else begin
      state   <= state_next;
      ctrl_en <= ctrl_next;
      pending <= pending_next;
      active  <= active_next;
      prev    <= bus.ext_int;
      primed  <= 1'b1;
      int_num <= num_next;
    end
  end

endmodule

// File: tb/tb_reflet_int_arbiter.sv
// Directed and randomized bench for reflet_int_arbiter against an
// integer-array reference model of the interrupt rules.
module tb_reflet_int_arbiter;
  localparam logic [15:0] BASE = 16'hFF07;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reflet_int_arbiter_if #(.addr_width(16)) bus_if ();

  reflet_int_arbiter #(
    .base_addr_size(16),
    .base_addr(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_ctrl, m_req, m_num, m_primed;
  int m_pend[4];
  int m_act[4];
  int m_prev[4];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: next state from the rules, evaluated with pre-edge inputs.
  task automatic model_step();
    int lvl, cand, off, acked, nctrl, nreq, nnum;
    int np[4];
    int na[4];
    logic [15:0] d;
    if (!reset) begin
      m_ctrl = 0; m_req = 0; m_num = 0; m_primed = 0;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_act[i] = 0; m_prev[i] = 0;
      end
      return;
    end
    lvl = -1;
    for (int i = 0; i < 4; i++) if (m_act[i] != 0) lvl = i;
    cand = -1;
    for (int i = lvl + 1; i < 4; i++) if (m_pend[i] != 0) cand = i;
    d = bus_if.addr - BASE;
    off = int'(d);
    acked = (m_req != 0 && bus_if.int_ack) ? 1 : 0;
    nctrl = m_ctrl;
    for (int i = 0; i < 4; i++) begin
      np[i] = m_pend[i];
      na[i] = m_act[i];
    end
    if (bus_if.enable && bus_if.write_en && off < 3) begin
      if (off == 0) nctrl = bus_if.data_in[0] ? 1 : 0;
      if (off == 1) for (int i = 0; i < 4; i++) if (bus_if.data_in[i]) np[i] = 0;
    end
    if (acked != 0) np[m_num] = 0;
    for (int i = 0; i < 4; i++)
      if (m_primed != 0 && bus_if.ext_int[i] && m_prev[i] == 0) np[i] = 1;
    if (bus_if.int_ret && lvl >= 0) na[lvl] = 0;
    if (acked != 0) na[m_num] = 1;
    nreq = m_req;
    nnum = m_num;
    if (m_req == 0) begin
      if (m_ctrl != 0 && cand >= 0) begin
        nreq = 1;
        nnum = cand;
      end
    end else if (acked != 0 || np[m_num] == 0 || nctrl == 0) begin
      nreq = 0;
    end
    m_ctrl = nctrl; m_req = nreq; m_num = nnum; m_primed = 1;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = np[i];
      m_act[i]  = na[i];
      m_prev[i] = bus_if.ext_int[i] ? 1 : 0;
    end
  endtask

  function automatic logic [7:0] model_rd(input int off);
    logic [7:0] v;
    v = 8'h00;
    if (off == 0) v[0] = (m_ctrl != 0);
    if (off == 1) for (int i = 0; i < 4; i++) v[i] = (m_pend[i] != 0);
    if (off == 2) for (int i = 0; i < 4; i++) v[i] = (m_act[i] != 0);
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("int_req", {7'h00, bus_if.int_req}, 8'(m_req));
    if (m_req != 0) chk("int_num", {6'h00, bus_if.int_num}, 8'(m_num));
    bus_if.write_en = 1'b0;
    bus_if.int_ack  = 1'b0;
    bus_if.int_ret  = 1'b0;
  endtask

  task automatic rd(input int off, output logic [7:0] v);
    bus_if.enable   = 1'b1;
    bus_if.write_en = 1'b0;
    bus_if.addr     = BASE + 16'(off);
    #1;
    v = bus_if.data_out;
  endtask

  task automatic chk_reg(input string tag, input int off, input logic [7:0] exp);
    logic [7:0] v;
    rd(off, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input int off, input logic [7:0] data);
    bus_if.enable   = 1'b1;
    bus_if.addr     = BASE + 16'(off);
    bus_if.data_in  = data;
    bus_if.write_en = 1'b1;
    tick();
  endtask

  task automatic ret_all();
    for (int i = 0; i < 4; i++) begin
      bus_if.int_ret = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [7:0] v;
    int         off;
    bus_if.enable   = 1'b0;
    bus_if.addr     = '0;
    bus_if.write_en = 1'b0;
    bus_if.data_in  = '0;
    bus_if.ext_int  = '0;
    bus_if.int_ack  = 1'b0;
    bus_if.int_ret  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    chk_reg("rst_ctrl", 0, 8'h00);
    chk_reg("rst_pend", 1, 8'h00);
    chk_reg("rst_act", 2, 8'h00);
    chk("rst_req", {7'h00, bus_if.int_req}, 8'h00);
    reset = 1'b1;
    tick();

    // Single request and acknowledge on line 1
    wr(0, 8'h01);
    chk_reg("ctrl_rd", 0, 8'h01);
    bus_if.ext_int = 4'b0010;
    tick();
    bus_if.ext_int = 4'b0000;
    chk_reg("lat_pend", 1, 8'h02);
    chk("lat_req0", {7'h00, bus_if.int_req}, 8'h00);
    tick();
    chk("lat_req1", {7'h00, bus_if.int_req}, 8'h01);
    chk("lat_num1", {6'h00, bus_if.int_num}, 8'h01);
    bus_if.int_ack = 1'b1;
    tick();
    chk_reg("ack_pend", 1, 8'h00);
    chk_reg("ack_act", 2, 8'h02);

    // Nesting: line 0 blocked under active 1, line 3 preempts
    bus_if.ext_int = 4'b0001;
    tick();
    bus_if.ext_int = 4'b0000;
    tick();
    chk("low_blocked", {7'h00, bus_if.int_req}, 8'h00);
    bus_if.ext_int = 4'b1000;
    tick();
    bus_if.ext_int = 4'b0000;
    tick();
    chk("nest_num3", {6'h00, bus_if.int_num}, 8'h03);
    bus_if.int_ack = 1'b1;
    tick();
    chk_reg("nest_act", 2, 8'h0A);
    bus_if.int_ret = 1'b1;
    tick();
    chk_reg("ret_act", 2, 8'h02);

    // Request stays on line 0 while line 3 arrives
    bus_if.int_ret = 1'b1;
    tick();
    chk_reg("ret2_act", 2, 8'h00);
    tick();
    chk("req0_num", {6'h00, bus_if.int_num}, 8'h00);
    bus_if.ext_int = 4'b1000;
    tick();
    bus_if.ext_int = 4'b0000;
    tick();
    tick();
    chk("stable_req", {7'h00, bus_if.int_req}, 8'h01);
    chk("stable_num", {6'h00, bus_if.int_num}, 8'h00);
    bus_if.int_ack = 1'b1;
    tick();
    chk_reg("ack0_act", 2, 8'h01);
    tick();
    chk("next_num3", {6'h00, bus_if.int_num}, 8'h03);
    bus_if.int_ack = 1'b1;
    tick();
    ret_all();

    // Pending accumulates with global enable off
    wr(0, 8'h00);
    bus_if.ext_int = 4'b0100;
    tick();
    bus_if.ext_int = 4'b0000;
    tick();
    tick();
    chk_reg("dis_pend", 1, 8'h04);
    chk("dis_req", {7'h00, bus_if.int_req}, 8'h00);
    bus_if.addr = BASE + 16'd3;
    #1;
    chk("unmapped", bus_if.data_out, 8'h00);
    bus_if.enable = 1'b0;
    bus_if.addr   = BASE + 16'd1;
    #1;
    chk("deselect", bus_if.data_out, 8'h00);
    bus_if.int_ack = 1'b1;
    tick();
    chk_reg("idle_ack_act", 2, 8'h00);
    chk_reg("idle_ack_pend", 1, 8'h04);
    wr(0, 8'h01);
    chk("en_req_lat", {7'h00, bus_if.int_req}, 8'h00);
    tick();
    chk("en_req", {7'h00, bus_if.int_req}, 8'h01);
    chk("en_num", {6'h00, bus_if.int_num}, 8'h02);
    bus_if.int_ack = 1'b1;
    tick();
    ret_all();

    // W1C collides with a new edge: set wins
    wr(0, 8'h00);
    bus_if.ext_int = 4'b0011;
    tick();
    bus_if.ext_int = 4'b0000;
    tick();
    chk_reg("w1c_pre", 1, 8'h03);
    bus_if.ext_int = 4'b0100;
    wr(1, 8'h0F);
    bus_if.ext_int = 4'b0000;
    chk_reg("w1c_set_wins", 1, 8'h04);

    // Reset aborts a live request; held line does not pend afterwards
    wr(0, 8'h01);
    tick();
    chk("pre_rst_req", {7'h00, bus_if.int_req}, 8'h01);
    bus_if.ext_int = 4'b0010;
    reset = 1'b0;
    tick();
    chk("rst_abort", {7'h00, bus_if.int_req}, 8'h00);
    chk_reg("rst2_ctrl", 0, 8'h00);
    chk_reg("rst2_pend", 1, 8'h00);
    chk_reg("rst2_act", 2, 8'h00);
    reset = 1'b1;
    tick();
    tick();
    chk_reg("held_no_pend", 1, 8'h00);
    bus_if.ext_int = 4'b0000;
    tick();

    // Randomized traffic against the model
    wr(0, 8'h01);
    for (int n = 0; n < 1500; n++) begin
      bus_if.ext_int = bus_if.ext_int ^ (4'($urandom) & 4'($urandom));
      bus_if.int_ack = (m_req != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus_if.int_ret = ($urandom_range(0, 5) == 0);
      bus_if.enable  = 1'b1;
      bus_if.addr    = BASE + 16'($urandom_range(0, 3));
      bus_if.data_in = 8'($urandom);
      if (bus_if.addr == BASE) bus_if.data_in[0] = ($urandom_range(0, 3) != 0);
      bus_if.write_en = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 249) != 0);
      tick();
      reset = 1'b1;
      off = int'($urandom_range(0, 2));
      rd(off, v);
      chk("rnd_reg", v, model_rd(off));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
